// File: rtl/step_alu.sv
// rtl/step_alu.sv - registered INC/DEC/ADD/REP step ALU with valid/ready handshakes
module step_alu #(
    parameter int WIDTH    = 8,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] numa,
    input  logic [WIDTH-1:0] numb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outa,
    output logic             ovf,
    output logic             busy
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);
    localparam logic [1:0] OP_INC = 2'd0;
    localparam logic [1:0] OP_DEC = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_REP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_d;
    logic             sticky;
    logic             sticky_d;
    logic             accept;
    logic [WIDTH:0]   in_res;
    logic [WIDTH:0]   run_res;

    // MSB of the returned value is the carry/borrow flag; low bits are the (possibly clamped) result
    function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s[WIDTH] && SATURATE != 0) s[WIDTH-1:0] = '1;
        return s;
    endfunction

    function automatic logic [WIDTH:0] sub_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} - {1'b0, b};
        if (s[WIDTH] && SATURATE != 0) s[WIDTH-1:0] = '0;
        return s;
    endfunction

    assign accept  = in_valid & in_ready & (state == S_IDLE);
    assign run_res = add_op(acc, STEP_W);

    always_comb begin
        in_res = '0;
        case (op)
            OP_INC:  in_res = add_op(numa, STEP_W);
            OP_DEC:  in_res = sub_op(numa, STEP_W);
            OP_ADD:  in_res = add_op(numa, numb);
            OP_REP:  in_res = {1'b0, numa};
            default: in_res = '0;
        endcase
    end

    always_comb begin
        acc_d    = acc;
        cnt_d    = cnt;
        sticky_d = sticky;
        if (accept) begin
            acc_d    = in_res[WIDTH-1:0];
            sticky_d = in_res[WIDTH];
            cnt_d    = numb;
        end else if (state == S_RUN) begin
            acc_d    = run_res[WIDTH-1:0];
            sticky_d = sticky | run_res[WIDTH];
            cnt_d    = cnt - ONE_W;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = (op == OP_REP && numb != '0) ? S_RUN : S_DONE;
            S_RUN:  if (cnt == ONE_W) next_state = S_DONE;
            S_DONE: if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
    end

    // Handshake flags are registered from next_state; the result is captured only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            outa      <= '0;
            ovf       <= 1'b0;
        end else begin
            acc       <= acc_d;
            cnt       <= cnt_d;
            sticky    <= sticky_d;
            in_ready  <= (next_state == S_IDLE);
            out_valid <= (next_state == S_DONE);
            if (next_state == S_DONE && state != S_DONE) begin
                outa <= acc_d;
                ovf  <= sticky_d;
            end
        end
    end

endmodule

// File: tb/tb_step_alu.sv
// tb/tb_step_alu.sv - scoreboard bench for step_alu over three WIDTH/STEP/SATURATE configurations
module tb_step_alu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] op;
    logic [7:0] numa;
    logic [7:0] numb;
    logic       out_ready;
    logic [2:0] rdy;
    logic [2:0] ov;
    logic [2:0] ovf;
    logic [2:0] bsy;
    logic [7:0] outa0, outa1, outa2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int bp_mode;

    typedef struct {
        logic [8:0] e0;
        logic [8:0] e1;
        logic [8:0] e2;
        int         lat;
        int         acc;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_alu #(.WIDTH(8), .STEP(1), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .op(op),
        .numa(numa), .numb(numb), .out_valid(ov[0]), .out_ready(out_ready),
        .outa(outa0), .ovf(ovf[0]), .busy(bsy[0]));
    step_alu #(.WIDTH(8), .STEP(1), .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .op(op),
        .numa(numa), .numb(numb), .out_valid(ov[1]), .out_ready(out_ready),
        .outa(outa1), .ovf(ovf[1]), .busy(bsy[1]));
    step_alu #(.WIDTH(8), .STEP(3), .SATURATE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .op(op),
        .numa(numa), .numb(numb), .out_valid(ov[2]), .out_ready(out_ready),
        .outa(outa2), .ovf(ovf[2]), .busy(bsy[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: apply the step rule n times with integer arithmetic and range checks
    function automatic logic [8:0] model(input int opc, input int a, input int b, input int step, input int sat);
        int r, n, d;
        bit o;
        r = a;
        o = 1'b0;
        n = (opc == 3) ? b : 1;
        d = (opc == 2) ? b : step;
        for (int i = 0; i < n; i++) begin
            if (opc == 1) r = r - d;
            else          r = r + d;
            if (r > 255) begin
                o = 1'b1;
                r = sat ? 255 : r - 256;
            end else if (r < 0) begin
                o = 1'b1;
                r = sat ? 0 : r + 256;
            end
        end
        return {o, 8'(r)};
    endfunction

    task automatic do_op(input int opc, input int a, input int b);
        exp_t e;
        int   n;
        @(negedge clk);
        in_valid = 1'b1;
        op       = 2'(opc);
        numa     = 8'(a);
        numb     = 8'(b);
        n = 0;
        while (rdy[0] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e.e0  = model(opc, a, b, 1, 0);
        e.e1  = model(opc, a, b, 1, 1);
        e.e2  = model(opc, a, b, 3, 0);
        e.lat = (opc == 3 && b != 0) ? b + 1 : 1;
        e.acc = cyc;
        q.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = ($urandom_range(0, 2) != 0);
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: checks flags and, while valid, the result against the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q.size() == 0) begin
                chk("busy_idle", bsy, 3'b000);
                chk("in_ready_idle", rdy, 3'b111);
                chk("out_valid_idle", ov, 3'b000);
            end else begin
                chk("busy_op", bsy, 3'b111);
                chk("in_ready_op", rdy, 3'b000);
                chk("out_valid_latency", ov, (cyc - q[0].acc + 1 >= q[0].lat) ? 3'b111 : 3'b000);
                if (ov[0] === 1'b1) begin
                    chk("result_u0", {ovf[0], outa0}, q[0].e0);
                    chk("result_u1_sat", {ovf[1], outa1}, q[0].e1);
                    chk("result_u2_step3", {ovf[2], outa2}, q[0].e2);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        op        = 2'd0;
        numa      = 8'd0;
        numb      = 8'd0;
        out_ready = 1'b1;
        bp_mode   = 2;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_in_ready", rdy, 3'b000);
        chk("reset_out_valid", ov, 3'b000);
        chk("reset_outa", {outa0, outa1, outa2}, 24'h0);
        chk("reset_ovf_busy", {ovf, bsy}, 6'b0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk("in_ready_before_edge", rdy, 3'b000);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", rdy, 3'b111);

        do_op(0, 8'hFE, 0);
        do_op(0, 8'hFF, 0);
        do_op(1, 8'h00, 0);
        do_op(2, 8'h80, 8'h80);
        do_op(2, 8'h12, 8'h34);
        do_op(3, 8'h10, 5);
        do_op(3, 8'h10, 0);
        do_op(3, 8'hFA, 3);
        do_op(3, 8'hFE, 4);
        drain();

        bp_mode = 1;
        do_op(0, 8'h10, 0);
        repeat (4) begin
            @(negedge clk);
            in_valid = 1'b1;
            op       = 2'd2;
            numa     = 8'($urandom);
            numb     = 8'($urandom);
            @(negedge clk);
            chk("bp_in_ready", rdy, 3'b000);
            in_valid = 1'b0;
        end
        bp_mode = 2;
        drain();
        do_op(2, 8'h12, 8'h34);
        drain();

        bp_mode = 0;
        repeat (60) begin
            int opc, a, b;
            opc = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0)
                a = $urandom_range(0, 1) ? 255 - $urandom_range(0, 3) : $urandom_range(0, 3);
            else
                a = $urandom_range(0, 255);
            b = (opc == 3) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            do_op(opc, a, b);
        end
        drain();
        bp_mode = 2;

        do_op(3, 8'h10, 200);
        repeat (30) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midop_reset_in_ready", rdy, 3'b000);
        chk("midop_reset_out_valid", ov, 3'b000);
        chk("midop_reset_outa", {outa0, outa1, outa2}, 24'h0);
        chk("midop_reset_ovf_busy", {ovf, bsy}, 6'b0);
        q.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        chk("release_in_ready_low", rdy, 3'b000);
        @(posedge clk);
        #1;
        chk("release_in_ready_high", rdy, 3'b111);
        do_op(0, 8'h01, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
